// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear FSM states,
// default geometry and a helper for locating a port inside a packed bus.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W_DEF   = 8;
  localparam int RF_DEPTH_DEF    = 32;
  localparam int RF_NUM_WR_DEF   = 2;
  localparam int RF_NUM_RD_DEF   = 2;
  localparam int RF_BYPASS_DEF   = 1;
  localparam int RF_ZERO_REG_DEF = 0;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Per-address write resolution: for every register, reports whether any port
// writes it this cycle and which data wins (highest-numbered port).
module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int NUM_WR = RF_NUM_WR_DEF,
  parameter int ADDR_W = $clog2(RF_DEPTH_DEF)
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DEPTH-1:0]         addr_hit,
  output logic [DEPTH*DATA_W-1:0]  addr_data
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr
      logic              hit;
      logic [DATA_W-1:0] data;

      // Ascending scan so a later (higher) port overrides an earlier one.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(gi)) begin
            hit  = 1'b1;
            data = wr_data[slice_lo(p, DATA_W) +: DATA_W];
          end
        end
      end

      assign addr_hit[gi]                       = hit;
      assign addr_data[gi*DATA_W +: DATA_W]     = data;
    end
  endgenerate

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with write priority, optional
// write-first bypass, optional zero register and a sequenced soft clear.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int NUM_WR   = RF_NUM_WR_DEF,
  parameter int NUM_RD   = RF_NUM_RD_DEF,
  parameter int BYPASS   = RF_BYPASS_DEF,
  parameter int ZERO_REG = RF_ZERO_REG_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR*$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]                 rd_en,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]          rd_data,
  input  logic                              clear_req,
  output logic                              clear_busy,
  output logic                              clear_done
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  rf_state_e         state_reg;
  logic [ADDR_W-1:0] clr_ptr_reg;
  logic              clear_busy_reg;
  logic              clear_done_reg;

  logic [DEPTH-1:0]        addr_hit;
  logic [DEPTH*DATA_W-1:0] addr_data;

  rf_write_arbiter #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .addr_hit  (addr_hit),
    .addr_data (addr_data)
  );

  // Writes are only accepted in IDLE, which is exactly when clear_busy is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) mem_reg[a] <= '0;
      state_reg      <= RF_IDLE;
      clr_ptr_reg    <= '0;
      clear_busy_reg <= 1'b0;
      clear_done_reg <= 1'b0;
    end else begin
      clear_done_reg <= 1'b0;
      case (state_reg)
        RF_IDLE: begin
          for (int a = 0; a < DEPTH; a++) begin
            if (addr_hit[a] && !(ZERO_REG != 0 && a == 0))
              mem_reg[a] <= addr_data[slice_lo(a, DATA_W) +: DATA_W];
          end
          if (clear_req) begin
            state_reg      <= RF_CLEAR;
            clr_ptr_reg    <= '0;
            clear_busy_reg <= 1'b1;
          end
        end
        RF_CLEAR: begin
          mem_reg[clr_ptr_reg] <= '0;
          if (clr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg      <= RF_IDLE;
            clear_busy_reg <= 1'b0;
            clear_done_reg <= 1'b1;
          end else begin
            clr_ptr_reg <= clr_ptr_reg + 1'b1;
          end
        end
        default: state_reg <= RF_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;

      assign ra = rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W];

      always_comb begin
        rd_val = '0;
        if (rd_en[gi]) begin
          if (ZERO_REG != 0 && ra == '0)
            rd_val = '0;
          else if (BYPASS != 0 && !clear_busy_reg && addr_hit[ra])
            rd_val = addr_data[slice_lo(int'(ra), DATA_W) +: DATA_W];
          else
            rd_val = mem_reg[ra];
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
    end
  endgenerate

  assign clear_busy = clear_busy_reg;
  assign clear_done = clear_done_reg;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three configurations checked against a
// behavioural array model, plus vector tables and clear/reset sequences.
module tb_register_file_mp;

  localparam int NI = 3;
  localparam int CFG_DW   [NI] = '{8, 16, 8};
  localparam int CFG_DEPTH[NI] = '{32, 64, 32};
  localparam int CFG_NW   [NI] = '{2, 3, 2};
  localparam int CFG_NR   [NI] = '{2, 4, 2};
  localparam int CFG_BP   [NI] = '{1, 1, 0};
  localparam int CFG_ZR   [NI] = '{0, 1, 0};

  logic clock = 1'b0;
  logic reset;

  logic [2:0]  wen  [NI];
  logic [5:0]  wad  [NI][3];
  logic [15:0] wdt  [NI][3];
  logic [3:0]  ren  [NI];
  logic [5:0]  rad  [NI][4];
  wire  [15:0] rdt  [NI][4];
  logic        creq [NI];
  wire         cbusy[NI];
  wire         cdone[NI];

  always #5 clock = ~clock;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DW  = CFG_DW[gi];
      localparam int DEP = CFG_DEPTH[gi];
      localparam int NW  = CFG_NW[gi];
      localparam int NR  = CFG_NR[gi];
      localparam int AW  = $clog2(DEP);

      logic [NW*AW-1:0] wa_p;
      logic [NW*DW-1:0] wd_p;
      logic [NR*AW-1:0] ra_p;
      wire  [NR*DW-1:0] rd_p;

      for (genvar p = 0; p < NW; p++) begin : g_w
        assign wa_p[p*AW +: AW] = wad[gi][p][AW-1:0];
        assign wd_p[p*DW +: DW] = wdt[gi][p][DW-1:0];
      end
      for (genvar q = 0; q < 4; q++) begin : g_r
        if (q < NR) begin : g_on
          assign ra_p[q*AW +: AW] = rad[gi][q][AW-1:0];
          assign rdt[gi][q]       = 16'(rd_p[q*DW +: DW]);
        end else begin : g_off
          assign rdt[gi][q] = '0;
        end
      end

      register_file_mp #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .NUM_WR   (NW),
        .NUM_RD   (NR),
        .BYPASS   (CFG_BP[gi]),
        .ZERO_REG (CFG_ZR[gi])
      ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wen[gi][NW-1:0]),
        .wr_addr    (wa_p),
        .wr_data    (wd_p),
        .rd_en      (ren[gi][NR-1:0]),
        .rd_addr    (ra_p),
        .rd_data    (rd_p),
        .clear_req  (creq[gi]),
        .clear_busy (cbusy[gi]),
        .clear_done (cdone[gi])
      );
    end
  endgenerate

  // Reference model: plain array plus a clear counter.
  logic [15:0] m_mem [NI][64];
  logic        m_busy[NI];
  int          m_idx [NI];
  logic        m_done[NI];
  int          busy_cnt[NI];
  int          done_cnt[NI];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [1:0] wen;
    logic [4:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic [1:0] ren;
    logic [4:0] ra0, ra1;
    logic [7:0] e0, e1;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dmask(input int k);
    return 16'((32'd1 << CFG_DW[k]) - 1);
  endfunction

  function automatic logic [15:0] exp_rd(input int k, input int q);
    logic [15:0] v;
    int a;
    if (!ren[k][q]) return 16'h0;
    a = int'(rad[k][q]) & (CFG_DEPTH[k] - 1);
    if (CFG_ZR[k] != 0 && a == 0) return 16'h0;
    v = m_mem[k][a];
    if (CFG_BP[k] != 0 && !m_busy[k]) begin
      for (int p = 0; p < CFG_NW[k]; p++)
        if (wen[k][p] && (int'(wad[k][p]) & (CFG_DEPTH[k] - 1)) == a) v = wdt[k][p] & dmask(k);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 64; a++) m_mem[k][a] = 16'h0;
      m_busy[k] = 1'b0;
      m_idx[k]  = 0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int a;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      m_done[k] = 1'b0;
      if (m_busy[k]) begin
        m_mem[k][m_idx[k]] = 16'h0;
        if (m_idx[k] == CFG_DEPTH[k] - 1) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
        end else begin
          m_idx[k]++;
        end
      end else begin
        for (int p = 0; p < CFG_NW[k]; p++) begin
          a = int'(wad[k][p]) & (CFG_DEPTH[k] - 1);
          if (wen[k][p] && !(CFG_ZR[k] != 0 && a == 0)) m_mem[k][a] = wdt[k][p] & dmask(k);
        end
        if (creq[k]) begin
          m_busy[k] = 1'b1;
          m_idx[k]  = 0;
        end
      end
    end
  endtask

  // Check every output against the model, then advance one clock.
  task automatic step();
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int q = 0; q < CFG_NR[k]; q++)
        chk($sformatf("model_rd i%0d q%0d", k, q), 32'(rdt[k][q]), 32'(exp_rd(k, q)));
      chk($sformatf("model_busy i%0d", k), 32'(cbusy[k]), 32'(m_busy[k]));
      chk($sformatf("model_done i%0d", k), 32'(cdone[k]), 32'(m_done[k]));
      if (cbusy[k]) busy_cnt[k]++;
      if (cdone[k]) done_cnt[k]++;
    end
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    for (int k = 0; k < NI; k++) begin
      wen[k]  = '0;
      ren[k]  = '0;
      creq[k] = 1'b0;
      for (int p = 0; p < 3; p++) begin wad[k][p] = '0; wdt[k][p] = '0; end
      for (int q = 0; q < 4; q++) rad[k][q] = '0;
    end
  endtask

  task automatic fill_a(input logic [7:0] val);
    for (int i = 0; i < 16; i++) begin
      idle();
      wen[0] = 3'b011;
      wad[0][0] = 6'(2 * i);     wdt[0][0] = 16'(val);
      wad[0][1] = 6'(2 * i + 1); wdt[0][1] = 16'(val);
      step();
    end
    idle();
  endtask

  task automatic check_a_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      idle();
      ren[0] = 4'b0011;
      rad[0][0] = 6'(2 * i);
      rad[0][1] = 6'(2 * i + 1);
      #1;
      chk($sformatf("%s r%0d", tag, 2 * i), 32'(rdt[0][0]), 32'h0);
      chk($sformatf("%s r%0d", tag, 2 * i + 1), 32'(rdt[0][1]), 32'h0);
      step();
    end
  endtask

  initial begin
    tbl[0] = '{2'b01, 5'd3, 5'd0, 8'hA5, 8'h00, 2'b00, 5'd0, 5'd3, 8'h00, 8'h00};
    tbl[1] = '{2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b10, 5'd0, 5'd3, 8'h00, 8'hA5};
    tbl[2] = '{2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd3, 8'h00, 8'h00};
    tbl[3] = '{2'b11, 5'd7, 5'd7, 8'h11, 8'h22, 2'b01, 5'd7, 5'd0, 8'h22, 8'h00};
    tbl[4] = '{2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b11, 5'd7, 5'd3, 8'h22, 8'hA5};
    tbl[5] = '{2'b01, 5'd3, 5'd0, 8'h3C, 8'h00, 2'b11, 5'd3, 5'd7, 8'h3C, 8'h22};
    tbl[6] = '{2'b10, 5'd0, 5'd9, 8'h00, 8'h99, 2'b11, 5'd9, 5'd3, 8'h99, 8'h3C};

    reset = 1'b1;
    idle();
    model_reset();
    for (int k = 0; k < NI; k++) begin busy_cnt[k] = 0; done_cnt[k] = 0; end
    @(posedge clock);
    @(negedge clock);
    step();
    reset = 1'b0;
    $display("reset applied");

    for (int i = 0; i < 7; i++) begin
      idle();
      wen[0] = {1'b0, tbl[i].wen};
      wad[0][0] = 6'(tbl[i].wa0); wdt[0][0] = 16'(tbl[i].wd0);
      wad[0][1] = 6'(tbl[i].wa1); wdt[0][1] = 16'(tbl[i].wd1);
      ren[0] = {2'b00, tbl[i].ren};
      rad[0][0] = 6'(tbl[i].ra0);
      rad[0][1] = 6'(tbl[i].ra1);
      #1;
      chk($sformatf("vec%0d rd0", i), 32'(rdt[0][0]), 32'(tbl[i].e0));
      chk($sformatf("vec%0d rd1", i), 32'(rdt[0][1]), 32'(tbl[i].e1));
      $display("vec %0d: wen=%b ren=%b rd0=%h rd1=%h", i, tbl[i].wen, tbl[i].ren, rdt[0][0], rdt[0][1]);
      step();
    end

    idle();
    wen[2] = 3'b001; wad[2][0] = 6'd9; wdt[2][0] = 16'h5A;
    ren[2] = 4'b0001; rad[2][0] = 6'd9;
    #1 chk("nobypass same cycle", 32'(rdt[2][0]), 32'h00);
    step();
    idle();
    ren[2] = 4'b0001; rad[2][0] = 6'd9;
    #1 chk("nobypass next cycle", 32'(rdt[2][0]), 32'h5A);
    step();
    $display("bypass-off sequence done");

    idle();
    wen[1] = 3'b001; wad[1][0] = 6'd0; wdt[1][0] = 16'h00FF;
    ren[1] = 4'b0001; rad[1][0] = 6'd0;
    #1 chk("zero reg bypass", 32'(rdt[1][0]), 32'h0);
    step();
    idle();
    ren[1] = 4'b0001; rad[1][0] = 6'd0;
    #1 chk("zero reg stored", 32'(rdt[1][0]), 32'h0);
    step();
    idle();
    wen[1] = 3'b111;
    for (int p = 0; p < 3; p++) wad[1][p] = 6'd40;
    wdt[1][0] = 16'h1111; wdt[1][1] = 16'h2222; wdt[1][2] = 16'h3333;
    ren[1] = 4'b0001; rad[1][0] = 6'd40;
    #1 chk("3port conflict bypass", 32'(rdt[1][0]), 32'h3333);
    step();
    idle();
    ren[1] = 4'b1000; rad[1][3] = 6'd40;
    #1 chk("3port conflict stored", 32'(rdt[1][3]), 32'h3333);
    step();
    $display("zero-register and wide-config sequence done");

    fill_a(8'hC3);
    creq[0] = 1'b1;
    step();
    creq[0] = 1'b0;
    busy_cnt[0] = 0; done_cnt[0] = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      if (c == 1) begin
        ren[0] = 4'b0011; rad[0][0] = 6'd0; rad[0][1] = 6'd31;
        #1;
        chk("clear r0 early", 32'(rdt[0][0]), 32'h00);
        chk("clear r31 early", 32'(rdt[0][1]), 32'hC3);
      end
      if (c == 10) begin
        wen[0] = 3'b001; wad[0][0] = 6'd5; wdt[0][0] = 16'h77;
        ren[0] = 4'b0001; rad[0][0] = 6'd5;
        #1 chk("clear write bypass", 32'(rdt[0][0]), 32'h00);
      end
      if (c == 11) begin
        ren[0] = 4'b0001; rad[0][0] = 6'd5;
        #1 chk("clear write dropped", 32'(rdt[0][0]), 32'h00);
      end
      step();
    end
    chk("clear busy cycles", 32'(busy_cnt[0]), 32'd32);
    chk("clear done pulses", 32'(done_cnt[0]), 32'd1);
    check_a_zero("after clear");
    $display("soft clear sequence done");

    fill_a(8'h5C);
    creq[0] = 1'b1;
    step();
    idle();
    busy_cnt[0] = 0; done_cnt[0] = 0;
    for (int c = 0; c < 10; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(cbusy[0]), 32'd0);
    chk("abort done", 32'(cdone[0]), 32'd0);
    check_a_zero("after abort");
    chk("abort no done pulse", 32'(done_cnt[0]), 32'd0);
    idle();
    wen[0] = 3'b011;
    wad[0][0] = 6'd0; wdt[0][0] = 16'h44;
    wad[0][1] = 6'd1; wdt[0][1] = 16'h55;
    step();
    idle();
    creq[0] = 1'b1;
    step();
    idle();
    busy_cnt[0] = 0; done_cnt[0] = 0;
    step();
    ren[0] = 4'b0011; rad[0][0] = 6'd0; rad[0][1] = 6'd1;
    #1;
    chk("restart r0", 32'(rdt[0][0]), 32'h00);
    chk("restart r1", 32'(rdt[0][1]), 32'h55);
    for (int c = 0; c < 40; c++) step();
    chk("restart busy cycles", 32'(busy_cnt[0]), 32'd32);
    chk("restart done pulses", 32'(done_cnt[0]), 32'd1);
    $display("reset mid-clear sequence done");

    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NI; k++) begin
        wen[k] = 3'($urandom);
        ren[k] = 4'($urandom);
        creq[k] = ($urandom_range(0, 59) == 0);
        for (int p = 0; p < 3; p++) begin
          wad[k][p] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
          wdt[k][p] = 16'($urandom);
        end
        for (int q = 0; q < 4; q++)
          rad[k][q] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the datapath, the successor to the fixed 32 x 8-bit, 2-read/2-write file. Width, depth and port counts are configurable. It adds deterministic same-address write priority, optional write-to-read bypass, an optional hard-wired zero register, and a sequenced soft-clear engine. Register reads feed the ALU operand muxes and writes come from the writeback stage.

## Interface
- DATA_W, 8: bits per register
- DEPTH, 32: number of registers (>= 2, power of two)
- NUM_WR, 2: write ports
- NUM_RD, 2: read ports
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads
- ZERO_REG, 0: 1 = entry 0 always reads 0, writes to it dropped
- ADDR_W (localparam) = $clog2(DEPTH)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  port p at [p*ADDR_W +: ADDR_W]
- wr_data  in  NUM_WR*DATA_W  port p at [p*DATA_W +: DATA_W]
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed as wr_addr
- rd_data  out  NUM_RD*DATA_W  combinational read data
- clear_req  in  1  request soft clear of all entries
- clear_busy  out  1  soft clear in progress
- clear_done  out  1  one-cycle pulse when soft clear completes

## Operation
- Write: at the rising edge, each port p with wr_en[p]=1 stores wr_data[p] at wr_addr[p].
- Same-address writes in one cycle: the highest-numbered enabled port wins. The other ports are dropped silently.
- Read: rd_data[q] = stored value at rd_addr[q] when rd_en[q]=1, else 0.
- BYPASS=1:
  - If any enabled write targets rd_addr[q] in the current cycle, rd_data[q] returns the winning write's data (write-first).
  - Bypass is suppressed while clear_busy=1 and for the zero register.
- ZERO_REG=1: reads of address 0 return 0; writes to address 0 never change the array.
- Soft clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_req=1. The pointer loads 0 and clear_busy asserts next cycle.
  - In CLEAR, one entry per cycle is zeroed at the pointer, then the pointer increments.
  - After entry DEPTH-1 is zeroed: return to IDLE, deassert clear_busy, and pulse clear_done for exactly one cycle in that same cycle.
  - clear_req while in CLEAR is ignored; no restart and no queuing.
  - All writes are ignored while clear_busy=1.
  - Reads during CLEAR return the current array contents: cleared entries read 0, uncleared entries keep old values.
- Reset: every entry becomes 0, FSM goes to IDLE, pointer resets to 0, clear_busy=0, clear_done=0. Reset overrides writes and clear_req in the same cycle. Reset asserted during CLEAR aborts the clear.
- Output reset values: clear_busy=0, clear_done=0. rd_data=0 for disabled ports and for all ports after reset.

## Timing
- Write to registered-read latency is 1 cycle; with BYPASS=1 the write is visible in the same cycle.
- Soft clear takes exactly DEPTH cycles with clear_busy=1, starting the cycle after clear_req is sampled. clear_done rises on cycle DEPTH+1.
- Read path is combinational from rd_addr/rd_en and array/bypass to rd_data, with no registers.
- Addresses out of range cannot occur because DEPTH is a power of two.

## Structure
- Shared package (regfile_pkg):
  - FSM state encoding (RF_IDLE, RF_CLEAR)
  - default parameter constants
  - helper function for packed-slice indexing
- One sub-module, rf_write_arbiter: combinational. It resolves, per address, the winning port and data (highest index wins). Its output drives both the array write enables and the bypass mux.
- The array and the clear FSM stay in the top module.

## Test plan
- Basic: default params, write 0xA5 to r3 via port 0; next cycle read r3 on port 1 -> 0xA5. With rd_en=0 -> 0x00.
- Conflict: port 0 writes 0x11 and port 1 writes 0x22 to r7 in the same cycle -> r7 = 0x22 afterwards. A same-cycle bypass read of r7 -> 0x22.
- Bypass off: BYPASS=0, write 0x5A to r9 while reading r9 (old value 0x00) -> 0x00 that cycle, 0x5A the next.
- Zero register: ZERO_REG=1, write 0xFF to r0 -> reads of r0 return 0x00, including same-cycle bypass.
- Soft clear: fill all 32 entries with 0xC3, pulse clear_req -> clear_busy high for 32 cycles.
  - r0 reads 0 after the first cycle while r31 still reads 0xC3.
  - A write of 0x77 to r5 mid-clear is ignored.
  - clear_done pulses once; all entries then read 0.
- Reset mid-clear: assert reset on cycle 10 of CLEAR -> next cycle clear_busy=0, clear_done stays 0, all entries 0. A new clear_req restarts from entry 0. Also run with DATA_W=16, DEPTH=64, NUM_WR=3, NUM_RD=4.
